// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared types and constants for the divider arbiter.
// Holds the arbiter FSM state enum, default data width and core latency.
package div_arb_pkg;

    localparam int DIV_DATA_W   = 32;
    localparam int DIV_CORE_LAT = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/div_core.sv
// div_core: unsigned restoring divider, one quotient bit per cycle.
// Ports: clk, rst (async, active-low), start, dividend, divisor in;
//        done pulse DIV_CORE_LAT cycles after start, quotient, remainder out.
module div_core
    import div_arb_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CW = $clog2(DIV_CORE_LAT + 1);

    logic              active;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] rem_q;

    logic [DATA_W-1:0] s_rem;
    logic [DATA_W-1:0] s_quo;
    logic [DATA_W-1:0] s_dvs;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   diff;
    logic              take;
    logic [DATA_W-1:0] n_rem;
    logic [DATA_W-1:0] n_quo;

    // The start cycle already performs the first iteration straight from
    // the operands, so the last bit lands one cycle before done.
    always_comb begin
        s_rem = start ? '0       : rem_q;
        s_quo = start ? dividend : quo_q;
        s_dvs = start ? divisor  : dvs_q;
        trial = {s_rem, s_quo[DATA_W-1]};
        diff  = trial - {1'b0, s_dvs};
        take  = (trial >= {1'b0, s_dvs});
        n_rem = take ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
        n_quo = {s_quo[DATA_W-2:0], take};
    end

    assign done      = active && (cnt == CW'(DIV_CORE_LAT));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            cnt    <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= CW'(1);
            dvs_q  <= divisor;
            quo_q  <= n_quo;
            rem_q  <= n_rem;
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
                // Narrow widths finish early and just idle to the fixed latency.
                if (int'(cnt) < DATA_W) begin
                    quo_q <= n_quo;
                    rem_q <= n_rem;
                end
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one div_core among NREQ requesters.
// Ports: clk, rst (async, active-low); req_valid/req_ready and packed
//        req_dividend/req_divisor per requester; one-hot rsp_valid,
//        rsp_ready, shared rsp_quotient/rsp_remainder; busy.
// Option: define DIV_ZERO_BYPASS_EN to answer divisor-0 requests in one
//         cycle without running the core.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_dividend,
    input  logic [NREQ*DATA_W-1:0] req_divisor,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]      rsp_quotient,
    output logic [DATA_W-1:0]      rsp_remainder,
    output logic                   busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    state_t            state_nx;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_any;
    logic [IW:0]       sum;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] q_r;
    logic [DATA_W-1:0] r_r;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              xfer;
    logic              zero_byp;
    logic              core_start;
    logic              core_done;
    logic [DATA_W-1:0] core_q;
    logic [DATA_W-1:0] core_r;

    // Walk down from the farthest slot so the one nearest rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(NREQ)) begin
                sum = sum - (IW + 1)'(NREQ);
            end
            if (req_valid[sum[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = sum[IW-1:0];
            end
        end
    end

    assign sel_a = req_dividend[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_b = req_divisor[int'(gnt_idx)*DATA_W +: DATA_W];
    assign xfer  = (state == IDLE) && gnt_any;

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_byp = (sel_b == '0);
`else
    assign zero_byp = 1'b0;
`endif

    assign req_ready = (rst && xfer) ? (NREQ'(1) << gnt_idx) : '0;
    assign rsp_valid = (state == RESP) ? (NREQ'(1) << owner) : '0;
    assign busy      = (state != IDLE);
    assign core_start    = (state == ISSUE);
    assign rsp_quotient  = q_r;
    assign rsp_remainder = r_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    state_nx = zero_byp ? RESP : ISSUE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (core_done) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[owner]) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            owner  <= '0;
            opa    <= '0;
            opb    <= '0;
            q_r    <= '0;
            r_r    <= '0;
        end else begin
            if (xfer) begin
                owner  <= gnt_idx;
                rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                opa    <= sel_a;
                opb    <= sel_b;
                if (zero_byp) begin
                    q_r <= '1;
                    r_r <= sel_a;
                end
            end
            if ((state == WAIT) && core_done) begin
                q_r <= core_q;
                r_r <= core_r;
            end
        end
    end

    div_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (core_start),
        .dividend (opa),
        .divisor  (opb),
        .done     (core_done),
        .quotient (core_q),
        .remainder(core_r)
    );

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed stimulus with a response scoreboard.
// Expectations are queued at grant time and checked by a monitor.
module tb_div_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 32;
`ifdef DIV_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 34;
`endif

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DATA_W-1:0] req_dividend;
    logic [NREQ*DATA_W-1:0] req_divisor;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]      rsp_quotient;
    logic [DATA_W-1:0]      rsp_remainder;
    logic                   busy;

    typedef struct {
        int          owner;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        int          t;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rise = 0;
    logic [NREQ-1:0] prev_v = '0;

    div_arbiter #(
        .NREQ  (NREQ),
        .DATA_W(DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_quotient (rsp_quotient),
        .rsp_remainder(rsp_remainder),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_v = '0;
        end else begin
            chk("req_ready_onehot", 64'($onehot0(req_ready)), 1);
            if (busy) chk("no_grant_busy", 64'(req_ready), 0);
            if (rsp_valid != '0 && prev_v == '0) begin
                rise = cyc;
                if (exp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 0);
            end
            if ((rsp_valid & rsp_ready) != '0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rsp_owner", 64'(rsp_valid), 64'(1 << e.owner));
                chk("rsp_quotient", 64'(rsp_quotient), 64'(e.q));
                chk("rsp_remainder", 64'(rsp_remainder), 64'(e.r));
                chk("rsp_latency", 64'(rise - e.t), 64'(e.lat));
            end
            prev_v = rsp_valid;
        end
    end

    task automatic set_ops(int i, logic [31:0] a, logic [31:0] b);
        req_dividend[i*DATA_W +: DATA_W] = a;
        req_divisor[i*DATA_W +: DATA_W]  = b;
    endtask

    task automatic push(int i, logic [31:0] q, logic [31:0] r, int lat);
        exp_t e;
        e.owner = i;
        e.q     = q;
        e.r     = r;
        e.lat   = lat;
        e.t     = cyc;
        exp_q.push_back(e);
    endtask

    task automatic do_req(int i, logic [31:0] a, logic [31:0] b,
                          logic [31:0] q, logic [31:0] r, int lat, bit imm);
        int n;
        @(posedge clk); #1;
        set_ops(i, a, b);
        req_valid[i] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready[i]) break;
            n++;
            if (n > 100) begin
                chk("grant_timeout", 64'(n), 0);
                req_valid[i] = 1'b0;
                return;
            end
        end
        if (imm) chk("same_cycle_grant", 64'(n), 0);
        push(i, q, r, lat);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) return;
        end
        chk("drain_timeout", 64'(exp_q.size()), 0);
    endtask

    initial begin
        int n;
        int bad;
        int order [5] = '{0, 1, 2, 3, 0};
        rst          = 1'b0;
        req_valid    = '1;
        rsp_ready    = '1;
        req_dividend = '0;
        req_divisor  = '0;
        set_ops(0, 100, 7);
        set_ops(1, 32'hFFFF_FFFF, 1);
        set_ops(2, 5, 9);
        set_ops(3, 1000, 10);
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_quotient", 64'(rsp_quotient), 0);
        chk("rst_remainder", 64'(rsp_remainder), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int g = 0; g < 5; g++) begin
            n = 0;
            forever begin
                @(negedge clk);
                if (req_ready != '0) break;
                n++;
                if (n > 100) break;
            end
            chk("grant_order", 64'(req_ready), 64'(1 << order[g]));
            case (order[g])
                0: push(0, 14, 2, 34);
                1: push(1, 32'hFFFF_FFFF, 0, 34);
                2: push(2, 0, 5, 34);
                default: push(3, 100, 0, 34);
            endcase
        end
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        do_req(0, 100, 7, 14, 2, 34, 1'b1);
        drain();
        do_req(1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 34, 1'b1);
        drain();
        do_req(2, 5, 9, 0, 5, 34, 1'b1);
        drain();
        do_req(3, 32'h1234, 0, 32'hFFFF_FFFF, 32'h1234, ZLAT, 1'b1);
        drain();

        rsp_ready = 4'b1011;
        do_req(2, 77, 5, 15, 2, 34, 1'b1);
        req_valid[1] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid[2]) break;
            n++;
            if (n > 60) break;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
            chk("hold_quotient", 64'(rsp_quotient), 15);
            chk("hold_remainder", 64'(rsp_remainder), 2);
            chk("hold_req_ready", 64'(req_ready), 0);
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rsp_ready = '1;
        drain();
        repeat (3) @(negedge clk);
        chk("no_stale_busy", 64'(busy), 0);

        do_req(1, 50, 5, 10, 0, 34, 1'b1);
        repeat (15) @(posedge clk);
        #1;
        chk("busy_in_wait", 64'(busy), 1);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_rsp_valid", 64'(rsp_valid), 0);
        chk("abort_quotient", 64'(rsp_quotient), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) bad++;
        end
        chk("abort_no_rsp", 64'(bad), 0);
        do_req(1, 9, 3, 3, 0, 34, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one divider (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the operand and result width.
REQ-003 The block SHALL have port clk  input  1  clock, all state updated on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 The block SHALL have port req_ready  output  NREQ  per-requester accept, at most one bit high.
REQ-007 The block SHALL have port req_dividend  input  NREQ*DATA_W  packed dividends, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port req_divisor  input  NREQ*DATA_W  packed divisors, same packing.
REQ-009 The block SHALL have port rsp_valid  output  NREQ  one-hot result-valid to the owning requester.
REQ-010 The block SHALL have port rsp_ready  input  NREQ  per-requester result accept.
REQ-011 The block SHALL have port rsp_quotient  output  DATA_W  unsigned quotient, valid while any rsp_valid is high.
REQ-012 The block SHALL have port rsp_remainder  output  DATA_W  unsigned remainder, valid while any rsp_valid is high.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-015 In IDLE, req_ready SHALL combinationally grant the first requester with req_valid high, searching round-robin from rr_ptr upward with wrap to 0.
REQ-016 A transfer SHALL occur on the edge where req_valid[i] and req_ready[i] are both high; operands and owner index are then latched and the FSM moves to ISSUE.
REQ-017 On a transfer, rr_ptr SHALL become (owner+1) mod NREQ.
REQ-018 A requester dropping req_valid before a transfer SHALL be legal and SHALL leave no state behind.
REQ-019 ISSUE SHALL last exactly one cycle, driving the core start high with the latched operands, then move to WAIT.
REQ-020 WAIT SHALL hold until the core done pulse, then capture quotient/remainder and move to RESP.
REQ-021 The core SHALL be an unsigned restoring divider that pulses done exactly 32 cycles after the start cycle; req-to-rsp_valid latency is therefore 34 cycles.
REQ-022 In RESP, rsp_valid[owner] SHALL be high and results stable until rsp_ready[owner] is high; the FSM then returns to IDLE.
REQ-023 rsp_ready on non-owner bits SHALL be ignored.
REQ-024 No new request SHALL be accepted outside IDLE; req_ready SHALL be all-zero in ISSUE, WAIT and RESP.
REQ-025 Divisor 0 routed through the core SHALL yield quotient all-ones and remainder equal to the dividend.
REQ-026 With equal continuous requests, each requester SHALL be served once per NREQ operations.

Reset
REQ-027 On rst low, state SHALL be IDLE, rr_ptr 0, owner 0, the result registers 0, and core start low.
REQ-028 Reset SHALL force req_ready, rsp_valid and busy to 0, and rsp_quotient and rsp_remainder to 0.
REQ-029 Reset asserted mid-operation SHALL abort the core, with no rsp_valid ever issued for the aborted request.

Configuration
REQ-030 With DIV_ZERO_BYPASS_EN defined, a transfer with divisor 0 SHALL go directly to RESP on the next cycle with quotient all-ones and remainder equal to the dividend, without starting the core (latency 1).
REQ-031 Without DIV_ZERO_BYPASS_EN, divisor 0 SHALL take the normal ISSUE/WAIT path with 34-cycle latency and the REQ-025 results.

Structure
REQ-032 Package div_arb_pkg SHALL hold the FSM state enum, the DATA_W default and the DIV_CORE_LAT=32 constant.
REQ-033 The divider datapath SHALL be a separate sub-module div_core (ports clk, rst, start, dividend, divisor, done, quotient, remainder) instantiated once.

Verification
REQ-034 The bench SHALL cover: single request, requester 0 with 100/7 -> req_ready[0] same cycle, rsp_valid[0] 34 cycles later, quotient 14, remainder 2.
REQ-035 The bench SHALL cover: all four requesters valid from reset -> grants in order 0,1,2,3,0 with rr_ptr wrap.
REQ-036 The bench SHALL cover: 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0; and 5/9 -> quotient 0, remainder 5.
REQ-037 The bench SHALL cover: divisor 0, dividend 0x1234 -> quotient 0xFFFFFFFF, remainder 0x1234, at latency 1 with DIV_ZERO_BYPASS_EN and latency 34 without.
REQ-038 The bench SHALL cover: rsp_ready held low 10 cycles -> rsp_valid and results stable, req_ready all-zero throughout.
REQ-039 The bench SHALL cover: rst pulsed low in cycle 15 of WAIT -> busy 0, no rsp_valid, and a following request 9/3 -> quotient 3, remainder 0.
